pbpix_tagger: RTL

PBPIX_TAGGER -- requirements
Module: pbpix_tagger

---
 rtl/pbpix_tagger.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pbpix_tagger.sv
// ---- pbpix_tagger : pixel FIFO tagging zero pixels, frame-last and per-frame zero count ----
// ---- Revision 1.0 ----
`default_nettype none

module pbpix_tagger #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  localparam int ZW   = $clog2(COLS*ROWS+1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clear,
  input  logic          src_rdy,
  output logic          src_ack,
  input  logic [DW-1:0] src_data,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic          dst_zero,
  output logic [DW-1:0] dst_data,
  output logic          dst_last,
  output logic          frame_done,
  output logic [ZW-1:0] zero_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [ZW-1:0] zrun_q, zrun_d, zcnt_q, zcnt_d;
  logic          fdone_q, fdone_d;

  logic          w_full, w_empty, w_push, w_pop;
  logic [DW-1:0] w_head;

  assign w_full  = (cnt_q == (AW+1)'(DEPTH));
  assign w_empty = (cnt_q == '0);
  assign w_head  = mem_q[rptr_q];

  // Gating with i_rstn keeps src_ack low while reset is held, yet high right after release.
  assign src_ack    = i_rstn && !w_full && !i_clear;
  assign dst_rdy    = !w_empty;
  assign dst_data   = dst_rdy ? w_head : '0;
  assign dst_zero   = dst_rdy && (w_head == '0);
  assign dst_last   = dst_rdy && (col_q == CW'(COLS-1)) && (row_q == RW'(ROWS-1));
  assign frame_done = fdone_q;
  assign zero_cnt   = zcnt_q;

  assign w_push = src_rdy && src_ack;
  assign w_pop  = dst_rdy && dst_ack && !i_clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    zrun_d  = zrun_q;
    zcnt_d  = zcnt_q;
    fdone_d = 1'b0;
    if (i_clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      col_d  = '0;
      row_d  = '0;
      zrun_d = '0;
      zcnt_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + AW'(1);
      if (w_pop)  rptr_d = rptr_q + AW'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      if (w_pop) begin
        if (col_q == CW'(COLS-1)) begin
          col_d = '0;
          row_d = (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
        // The last pixel's own zero flag is folded into the published count.
        if (dst_last) begin
          zcnt_d  = zrun_q + ZW'(dst_zero);
          zrun_d  = '0;
          fdone_d = 1'b1;
        end else begin
          zrun_d = zrun_q + ZW'(dst_zero);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      zrun_q  <= '0;
      zcnt_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      zrun_q  <= zrun_d;
      zcnt_q  <= zcnt_d;
      fdone_q <= fdone_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) mem_q[wptr_q] <= src_data;
  end

endmodule

`default_nettype wire
